// File: rtl/upload_frame_parser.sv
// Receive-side decoder for 0xAA 0x44 | source | len_H | len_L | payload | checksum frames.
// Recovers sync, forwards payload tagged with its source, and reports per-frame status.
module upload_frame_parser #(
    parameter logic [7:0]  FRAME_HEADER_H = 8'hAA,
    parameter logic [7:0]  FRAME_HEADER_L = 8'h44,
    parameter logic [15:0] MAX_LEN        = 16'd1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [7:0]  out_data,
    output logic [7:0]  out_source,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        out_last,
    output logic        frame_done,
    output logic        frame_ok,
    output logic        err_checksum,
    output logic        err_length,
    output logic [15:0] good_count,
    output logic [15:0] bad_count
);

    typedef enum logic [2:0] {
        StHuntH,
        StHuntL,
        StSrc,
        StLenH,
        StLenL,
        StPayload,
        StCsum
    } state_e;

    state_e      state_q, state_d;
    logic [7:0]  src_q, src_d;
    logic [7:0]  len_h_q, len_h_d;
    logic [7:0]  csum_q, csum_d;
    logic [15:0] rem_q, rem_d;
    logic [15:0] good_q, good_d;
    logic [15:0] bad_q, bad_d;
    logic        done_q, done_d;
    logic        ok_q, ok_d;
    logic        errc_q, errc_d;
    logic        errl_q, errl_d;

    logic        in_payload;
    logic        accept;
    logic [15:0] len_full;
    logic [15:0] good_inc;
    logic [15:0] bad_inc;

    // Payload is a zero-latency pass-through; every other byte is consumed immediately.
    assign in_payload = (state_q == StPayload);
    assign in_ready   = in_payload ? out_ready : 1'b1;
    assign out_valid  = in_payload && in_valid;
    assign out_data   = in_payload ? in_data : 8'h00;
    assign out_last   = in_payload && (rem_q == 16'd1);

    assign accept   = in_valid && in_ready;
    assign len_full = {len_h_q, in_data};
    assign good_inc = (good_q != 16'hFFFF) ? good_q + 16'd1 : good_q;
    assign bad_inc  = (bad_q != 16'hFFFF) ? bad_q + 16'd1 : bad_q;

    always_comb begin
        state_d = state_q;
        src_d   = src_q;
        len_h_d = len_h_q;
        csum_d  = csum_q;
        rem_d   = rem_q;
        good_d  = good_q;
        bad_d   = bad_q;
        done_d  = 1'b0;
        ok_d    = 1'b0;
        errc_d  = 1'b0;
        errl_d  = 1'b0;

        if (accept) begin
            unique case (state_q)
                StHuntH: begin
                    if (in_data == FRAME_HEADER_H) state_d = StHuntL;
                end
                StHuntL: begin
                    if (in_data == FRAME_HEADER_L) begin
                        state_d = StSrc;
                    end else if (in_data != FRAME_HEADER_H) begin
                        state_d = StHuntH;
                    end
                end
                StSrc: begin
                    src_d   = in_data;
                    csum_d  = in_data;
                    state_d = StLenH;
                end
                StLenH: begin
                    len_h_d = in_data;
                    csum_d  = csum_q ^ in_data;
                    state_d = StLenL;
                end
                StLenL: begin
                    csum_d = csum_q ^ in_data;
                    if (len_full > MAX_LEN) begin
                        errl_d  = 1'b1;
                        bad_d   = bad_inc;
                        state_d = StHuntH;
                    end else if (len_full == 16'd0) begin
                        state_d = StCsum;
                    end else begin
                        rem_d   = len_full;
                        state_d = StPayload;
                    end
                end
                StPayload: begin
                    csum_d = csum_q ^ in_data;
                    rem_d  = rem_q - 16'd1;
                    if (rem_q == 16'd1) state_d = StCsum;
                end
                StCsum: begin
                    done_d = 1'b1;
                    if (in_data == csum_q) begin
                        ok_d   = 1'b1;
                        good_d = good_inc;
                    end else begin
                        errc_d = 1'b1;
                        bad_d  = bad_inc;
                    end
                    state_d = StHuntH;
                end
                default: state_d = StHuntH;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StHuntH;
            src_q   <= 8'h00;
            len_h_q <= 8'h00;
            csum_q  <= 8'h00;
            rem_q   <= 16'd0;
            good_q  <= 16'd0;
            bad_q   <= 16'd0;
            done_q  <= 1'b0;
            ok_q    <= 1'b0;
            errc_q  <= 1'b0;
            errl_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            src_q   <= src_d;
            len_h_q <= len_h_d;
            csum_q  <= csum_d;
            rem_q   <= rem_d;
            good_q  <= good_d;
            bad_q   <= bad_d;
            done_q  <= done_d;
            ok_q    <= ok_d;
            errc_q  <= errc_d;
            errl_q  <= errl_d;
        end
    end

    assign out_source   = src_q;
    assign frame_done   = done_q;
    assign frame_ok     = ok_q;
    assign err_checksum = errc_q;
    assign err_length   = errl_q;
    assign good_count   = good_q;
    assign bad_count    = bad_q;

endmodule

// File: doc/upload_frame_parser.md
# upload_frame_parser

Receive-side decoder for the upload frame format `0xAA 0x44 | source | length_H | length_L | payload[length] | checksum`. It consumes the byte stream produced by the upload packer/arbiter chain, for example in loopback or on a host-facing bridge. It recovers frame sync, strips the header, and forwards payload bytes tagged with their source. Each frame ends with a one-cycle pass/fail indication and updated statistics.

## Interface
Parameters:
- `FRAME_HEADER_H`, default `8'hAA`: first sync byte.
- `FRAME_HEADER_L`, default `8'h44`: second sync byte.
- `MAX_LEN`, default `16'd1024`: largest accepted payload length.

Ports:
- `clk`  in  1  system clock; the block has one clock.
- `rst`  in  1  synchronous, active-high reset.
- `in_data`  in  8  incoming stream byte.
- `in_valid`  in  1  `in_data` is valid.
- `in_ready`  out  1  the block accepts `in_data` this cycle.
- `out_data`  out  8  payload byte.
- `out_source`  out  8  source byte of the current frame.
- `out_valid`  out  1  payload byte is valid.
- `out_ready`  in  1  downstream accepts the payload byte.
- `out_last`  out  1  marks the final payload byte of the frame.
- `frame_done`  out  1  one-cycle pulse when a frame ends.
- `frame_ok`  out  1  qualifies `frame_done`: checksum matched.
- `err_checksum`  out  1  qualifies `frame_done`: checksum mismatch.
- `err_length`  out  1  one-cycle pulse when a received length exceeds `MAX_LEN`.
- `good_count`  out  16  count of good frames; saturates.
- `bad_count`  out  16  count of checksum and length errors; saturates.

## Operation
- A byte is accepted on any cycle with `in_valid && in_ready`.
- The checksum is the XOR of the source byte, both length bytes and every payload byte. The header bytes are excluded.
- States and transitions on each accepted byte:
  - HUNT_H: byte equals `FRAME_HEADER_H` → HUNT_L; otherwise stay.
  - HUNT_L:
    - byte equals `FRAME_HEADER_L` → SRC.
    - byte equals `FRAME_HEADER_H` → stay in HUNT_L (handles repeated `0xAA`).
    - anything else → HUNT_H.
  - SRC: latch `out_source`, set `csum` = byte → LEN_H.
  - LEN_H: latch `len[15:8]`, XOR into `csum` → LEN_L.
  - LEN_L: form the full length from `len[15:8]` and this byte, XOR into `csum`.
    - length > `MAX_LEN` → pulse `err_length`, increment `bad_count` → HUNT_H.
    - length = 0 → CSUM.
    - otherwise load `remaining` = length → PAYLOAD.
  - PAYLOAD:
    - each accepted byte is XORed into `csum` and decrements `remaining`.
    - `remaining` == 1 at acceptance → CSUM.
  - CSUM: compare the byte with `csum`.
    - Assert `frame_done` together with either `frame_ok` or `err_checksum`.
    - Increment `good_count` or `bad_count` accordingly.
    - Next state → HUNT_H.
- Payload is forwarded before the checksum is known. Downstream decides what to do with the frame using `frame_done` and its qualifiers.
- Counters saturate at `16'hFFFF`; they never wrap.

## Timing
- Reset state:
  - State = HUNT_H.
  - `in_ready` = 1.
  - `out_valid`, `out_last`, `frame_done`, `frame_ok`, `err_checksum`, `err_length` = 0.
  - `out_source` = 0, `out_data` = 0.
  - Both counters = 0.
- In PAYLOAD, the datapath is a combinational pass-through with zero latency:
  - `out_valid` = `in_valid`
  - `out_data` = `in_data`
  - `in_ready` = `out_ready`
  - `out_last` = (`remaining` == 1)
- In every other state: `in_ready` = 1, `out_valid` = 0. Header, length and checksum bytes are consumed at one byte per cycle.
- Payload backpressure: while `out_valid && !out_ready`, the byte is not consumed and `remaining` and `csum` hold.
- `frame_done`, `frame_ok`, `err_checksum` and `err_length` are registered. They are high for exactly the cycle after the checksum (or bad length) byte is accepted.
- Counters update on that same cycle.
- Back-to-back frames: a header byte may be accepted on the cycle after the checksum byte, with no idle cycles required.
- Reset mid-frame: the block returns to HUNT_H on the next edge.
  - No `frame_done` is issued for the partial frame.
  - Partial bytes are discarded and counters clear.
- No timeout: a stalled stream holds its state indefinitely.

## Test plan
- Good frame `AA 44 0A 00 05 00 12 34 56 78 07`:
  - 5 payload bytes appear on the output with `out_source`=0x0A.
  - `out_last` is set on 0x78.
  - `frame_done` and `frame_ok` pulse once; `good_count`=1.
- The same frame with checksum 0x08:
  - The payload still passes through.
  - `err_checksum` pulses; `bad_count`=1, `good_count` unchanged.
- Leading garbage `11 AA AA 44 …` then a valid frame:
  - Sync is found via the repeated-`0xAA` path.
  - The frame decodes as good.
- Zero-length frame `AA 44 03 00 00 03`:
  - No `out_valid`.
  - `frame_ok` pulses.
- Length 0x0500 with `MAX_LEN`=1024:
  - `err_length` pulses and the parser rehunts.
  - A following valid frame decodes correctly.
- Randomized `out_ready` stalls during a 64-byte payload, with `rst` asserted mid-payload in a second frame:
  - Payload bytes arrive in order with nothing dropped.
  - The checksum result is correct.
  - After reset, no `frame_done` is issued and all outputs and counters return to their reset values.
